multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Single clock, asynchronous active-high reset; the block SHALL have no parameters.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 OpCode  in  6  IR[31:26], stable from ID onward.
REQ-005 Funct  in  6  IR[5:0], stable from ID onward.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes/selects.
REQ-007 ExtOp  out  1  1=sign-extend immediate, 0=zero-extend.
REQ-008 LuiOp  out  1  1=immediate placed in upper half.
REQ-009 RegDst  out  2  00 rt, 01 rd, 10 $31.
REQ-010 MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
REQ-011 ALUSrcA  out  2  00 PC, 01 A, 10 shamt.
REQ-012 ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-013 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A.
REQ-014 ALUOp  out  4  [2:0] 000 add, 001 sub, 100 and, 101 slt, 010 use Funct; [3]=1 unsigned.

Function
REQ-015 FSM states SHALL be IF, ID, EX, MEM, WB; outputs are combinational from state, OpCode, Funct; unlisted outputs are 0.
REQ-016 IF: MemRead, IRWrite, PCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00; next ID unconditionally, independent of OpCode.
REQ-017 ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=0000 (branch target to ALUOut).
REQ-018 ID, j (0x02): PCWrite=1, PCSource=10, next IF; jal (0x03): additionally RegWrite=1, RegDst=10, MemtoReg=10.
REQ-019 ID, illegal OpCode or R-type with unsupported Funct: no writes, next IF; all other legal ops next EX.
REQ-020 EX, R-type (Funct 0x00,02,03,20-27,2A,2B,2F): ALUSrcA=10 for shifts else 01, ALUSrcB=00, ALUOp=0010, next WB.
REQ-021 EX, jr (Funct 0x08): PCWrite=1, PCSource=11, next IF; jalr (0x09) additionally RegWrite=1, RegDst=01, MemtoReg=10.
REQ-022 EX, immediates (ALUSrcA=01, ALUSrcB=10, next WB): addi 0000/ExtOp1, addiu 1000/ExtOp1, andi 0100/ExtOp0, slti 0101/ExtOp1, sltiu 1101/ExtOp1, lui 0000/LuiOp1.
REQ-023 EX, lw/sw: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=0000, next MEM.
REQ-024 EX, beq (0x04): ALUSrcA=01, ALUSrcB=00, ALUOp=0001, PCWriteCond=1, PCSource=01, next IF.
REQ-025 MEM: IorD=1; lw MemRead=1 next WB; sw MemWrite=1 next IF.
REQ-026 WB: RegWrite=1, next IF; lw RegDst=00 MemtoReg=01; R-type RegDst=01 MemtoReg=00; immediates RegDst=00 MemtoReg=00.
REQ-027 Cycle counts SHALL be: j/jal/illegal 2, beq/jr/jalr 3, R-type/immediate/sw 4, lw 5.
REQ-028 No state SHALL assert MemRead and MemWrite together, nor more than one of PCWrite/RegWrite per register target per cycle beyond those listed.

Reset
REQ-029 Reset assertion SHALL force state IF asynchronously and hold every output at 0 while reset is high.
REQ-030 Reset mid-instruction SHALL abort it with no further PC, register or memory write; first cycle after release is IF.

Structure
REQ-031 Shared package SHALL hold state encoding, OpCode/Funct constants, ALUOp codes and all mux-select encodings.
REQ-032 One sub-module controller_decode (combinational: state, OpCode, Funct -> outputs, next state); top holds only the state register.

Verification
REQ-033 Reset high mid-EX of lw -> all outputs 0; after release IF with PCWrite=1, MemRead=1.
REQ-034 lw (0x23) -> states IF,ID,EX,MEM,WB; MEM IorD=1 MemRead=1; WB RegWrite=1 MemtoReg=01.
REQ-035 sltiu (0x0B) -> EX ALUOp=1101 ExtOp=1; WB RegDst=00; addiu -> ALUOp=1000.
REQ-036 beq -> 3 cycles, EX PCWriteCond=1 PCSource=01 ALUOp=0001, RegWrite never 1.
REQ-037 jal -> 2 cycles, ID PCWrite=1 PCSource=10 RegDst=10 MemtoReg=10; jalr -> EX RegDst=01 PCSource=11.
REQ-038 OpCode 0x3F -> IF,ID,IF; no write strobe asserted in ID.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// constants, ALUOp codes, datapath mux selects and the instruction classifier.
package multi_cycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_X2F   = 6'h2F;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_ADDU  = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] SA_PC = 2'b00, SA_A = 2'b01, SA_SHAMT = 2'b10;
  localparam logic [1:0] SB_B = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_IMM_SL2 = 2'b11;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_A = 2'b11;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_R_ALU, IC_R_SHIFT, IC_JR, IC_JALR,
    IC_IMM, IC_LW, IC_SW, IC_BEQ, IC_J, IC_JAL
  } iclass_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic iclass_e classify(input logic [5:0] op, input logic [5:0] fn);
    iclass_e c;
    c = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)           c = IC_R_SHIFT;
        else if (fn == FN_JR)                                       c = IC_JR;
        else if (fn == FN_JALR)                                     c = IC_JALR;
        else if ((fn >= FN_ALU_LO && fn <= FN_ALU_HI) || fn == FN_SLT ||
                 fn == FN_SLTU || fn == FN_X2F)                     c = IC_R_ALU;
        else                                                        c = IC_ILLEGAL;
      end
      OP_J:     c = IC_J;
      OP_JAL:   c = IC_JAL;
      OP_BEQ:   c = IC_BEQ;
      OP_LW:    c = IC_LW;
      OP_SW:    c = IC_SW;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: c = IC_IMM;
      default:  c = IC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_decode.sv
// Combinational half of the controller: next state and all datapath controls
// derived from the current state and the instruction fields.
module controller_decode
  import multi_cycle_controller_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output state_e     state_next_o,
  output ctrl_t      ctrl_o
);

  iclass_e iclass;
  assign iclass = classify(opcode_i, funct_i);

  always_comb begin
    state_next_o = ST_IF;
    case (state_i)
      ST_IF: state_next_o = ST_ID;
      ST_ID: begin
        if (iclass == IC_ILLEGAL || iclass == IC_J || iclass == IC_JAL) state_next_o = ST_IF;
        else                                                             state_next_o = ST_EX;
      end
      ST_EX: begin
        case (iclass)
          IC_LW, IC_SW:                   state_next_o = ST_MEM;
          IC_R_ALU, IC_R_SHIFT, IC_IMM:   state_next_o = ST_WB;
          default:                        state_next_o = ST_IF;
        endcase
      end
      ST_MEM:  state_next_o = (iclass == IC_LW) ? ST_WB : ST_IF;
      default: state_next_o = ST_IF;
    endcase
  end

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_IF: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = SA_PC;
        ctrl_o.alu_src_b = SB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCS_ALU;
      end
      ST_ID: begin
        // Branch target is computed speculatively into ALUOut for every opcode.
        ctrl_o.alu_src_a = SA_PC;
        ctrl_o.alu_src_b = SB_IMM_SL2;
        ctrl_o.ext_op    = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        if (iclass == IC_J || iclass == IC_JAL) begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCS_JUMP;
        end
        if (iclass == IC_JAL) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = RD_RA;
          ctrl_o.mem_to_reg = M2R_PC;
        end
      end
      ST_EX: begin
        case (iclass)
          IC_R_ALU, IC_R_SHIFT: begin
            ctrl_o.alu_src_a = (iclass == IC_R_SHIFT) ? SA_SHAMT : SA_A;
            ctrl_o.alu_src_b = SB_B;
            ctrl_o.alu_op    = ALU_FUNCT;
          end
          IC_JR, IC_JALR: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCS_A;
            if (iclass == IC_JALR) begin
              ctrl_o.reg_write  = 1'b1;
              ctrl_o.reg_dst    = RD_RD;
              ctrl_o.mem_to_reg = M2R_PC;
            end
          end
          IC_IMM: begin
            ctrl_o.alu_src_a = SA_A;
            ctrl_o.alu_src_b = SB_IMM;
            case (opcode_i)
              OP_ADDI:  begin ctrl_o.alu_op = ALU_ADD;  ctrl_o.ext_op = 1'b1; end
              OP_ADDIU: begin ctrl_o.alu_op = ALU_ADDU; ctrl_o.ext_op = 1'b1; end
              OP_ANDI:  begin ctrl_o.alu_op = ALU_AND;  ctrl_o.ext_op = 1'b0; end
              OP_SLTI:  begin ctrl_o.alu_op = ALU_SLT;  ctrl_o.ext_op = 1'b1; end
              OP_SLTIU: begin ctrl_o.alu_op = ALU_SLTU; ctrl_o.ext_op = 1'b1; end
              OP_LUI:   begin ctrl_o.alu_op = ALU_ADD;  ctrl_o.lui_op = 1'b1; end
              default:  ctrl_o.alu_op = ALU_ADD;
            endcase
          end
          IC_LW, IC_SW: begin
            ctrl_o.alu_src_a = SA_A;
            ctrl_o.alu_src_b = SB_IMM;
            ctrl_o.ext_op    = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
          end
          IC_BEQ: begin
            ctrl_o.alu_src_a     = SA_A;
            ctrl_o.alu_src_b     = SB_B;
            ctrl_o.alu_op        = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCS_ALUOUT;
          end
          default: ctrl_o = '0;
        endcase
      end
      ST_MEM: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_read  = (iclass == IC_LW);
        ctrl_o.mem_write = (iclass == IC_SW);
      end
      ST_WB: begin
        ctrl_o.reg_write = 1'b1;
        if (iclass == IC_LW) begin
          ctrl_o.reg_dst    = RD_RT;
          ctrl_o.mem_to_reg = M2R_MDR;
        end else if (iclass == IC_R_ALU || iclass == IC_R_SHIFT) begin
          ctrl_o.reg_dst    = RD_RD;
          ctrl_o.mem_to_reg = M2R_ALUOUT;
        end else begin
          ctrl_o.reg_dst    = RD_RT;
          ctrl_o.mem_to_reg = M2R_ALUOUT;
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control unit: holds the FSM state register and forces all
// controls low while reset is asserted.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  controller_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (OpCode),
    .funct_i      (Funct),
    .state_next_o (state_d),
    .ctrl_o       (ctrl)
  );

  // State already reads IF during reset, so the IF strobes must be masked here.
  assign ctrl_out = reset ? '0 : ctrl;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.iord;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign ExtOp       = ctrl_out.ext_op;
  assign LuiOp       = ctrl_out.lui_op;
  assign RegDst      = ctrl_out.reg_dst;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign PCSource    = ctrl_out.pc_source;
  assign ALUOp       = ctrl_out.alu_op;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: directed vector table, reset-abort sequences
// and randomized instruction streams checked against a per-instruction model.
module tb_multi_cycle_controller;

  logic       clk, reset;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .LuiOp(LuiOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic H = 1'b1, L = 1'b0;

  int tests = 0;
  int fails = 0;

  // Control word layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegWrite
  // ExtOp LuiOp RegDst MemtoReg ALUSrcA ALUSrcB PCSource ALUOp
  function automatic logic [22:0] cw(input logic pcw, pcwc, iord, mr, mw, irw, rw, ext, lui,
                                     input logic [1:0] rd, m2r, sa, sb, ps,
                                     input logic [3:0] aop);
    return {pcw, pcwc, iord, mr, mw, irw, rw, ext, lui, rd, m2r, sa, sb, ps, aop};
  endfunction

  function automatic logic [22:0] outw();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
            RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp};
  endfunction

  logic [22:0] W_IF, W_ID, W_ZERO;
  initial begin
    W_IF   = cw(H,L,L,H,L,H,L,L,L,2'd0,2'd0,2'd0,2'd1,2'd0,4'd0);
    W_ID   = cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd0,2'd3,2'd0,4'd0);
    W_ZERO = '0;
  end

  task automatic check_w(input string name, input logic [22:0] act, input logic [22:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: expected control word for each cycle of one instruction.
  logic [22:0] exp_w [0:8];
  int          exp_n;

  task automatic model(input logic [5:0] op, input logic [5:0] fn);
    logic r_alu;
    r_alu = (op == 6'h00) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 ||
            (fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B || fn == 6'h2F);
    for (int i = 0; i < 9; i++) exp_w[i] = '0;
    exp_w[0] = W_IF;
    exp_w[1] = W_ID;
    exp_n = 2;
    if (op == 6'h02) begin
      exp_w[1] = cw(H,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd0,2'd3,2'd2,4'd0);
    end else if (op == 6'h03) begin
      exp_w[1] = cw(H,L,L,L,L,L,H,H,L,2'd2,2'd2,2'd0,2'd3,2'd2,4'd0);
    end else if (r_alu) begin
      exp_w[2] = cw(L,L,L,L,L,L,L,L,L,2'd0,2'd0,(fn <= 6'h03) ? 2'd2 : 2'd1,2'd0,2'd0,4'b0010);
      exp_w[3] = cw(L,L,L,L,L,L,H,L,L,2'd1,2'd0,2'd0,2'd0,2'd0,4'd0);
      exp_n = 4;
    end else if (op == 6'h00 && fn == 6'h08) begin
      exp_w[2] = cw(H,L,L,L,L,L,L,L,L,2'd0,2'd0,2'd0,2'd0,2'd3,4'd0);
      exp_n = 3;
    end else if (op == 6'h00 && fn == 6'h09) begin
      exp_w[2] = cw(H,L,L,L,L,L,H,L,L,2'd1,2'd2,2'd0,2'd0,2'd3,4'd0);
      exp_n = 3;
    end else if (op == 6'h04) begin
      exp_w[2] = cw(L,H,L,L,L,L,L,L,L,2'd0,2'd0,2'd1,2'd0,2'd1,4'b0001);
      exp_n = 3;
    end else if (op == 6'h23) begin
      exp_w[2] = cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd1,2'd2,2'd0,4'd0);
      exp_w[3] = cw(L,L,H,H,L,L,L,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0);
      exp_w[4] = cw(L,L,L,L,L,L,H,L,L,2'd0,2'd1,2'd0,2'd0,2'd0,4'd0);
      exp_n = 5;
    end else if (op == 6'h2B) begin
      exp_w[2] = cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd1,2'd2,2'd0,4'd0);
      exp_w[3] = cw(L,L,H,L,H,L,L,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0);
      exp_n = 4;
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h0A || op == 6'h0B ||
                 op == 6'h0C || op == 6'h0F) begin
      logic [3:0] aop;
      logic       ext, lui;
      ext = (op != 6'h0C && op != 6'h0F);
      lui = (op == 6'h0F);
      case (op)
        6'h09:   aop = 4'b1000;
        6'h0A:   aop = 4'b0101;
        6'h0B:   aop = 4'b1101;
        6'h0C:   aop = 4'b0100;
        default: aop = 4'b0000;
      endcase
      exp_w[2] = cw(L,L,L,L,L,L,L,ext,lui,2'd0,2'd0,2'd1,2'd2,2'd0,aop);
      exp_w[3] = cw(L,L,L,L,L,L,H,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0);
      exp_n = 4;
    end
  endtask

  // Observed words of one instruction, from its IF up to the next IF.
  logic [22:0] seen [0:8];
  int          seen_n;

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op;
    Funct  = fn;
    seen_n = 0;
    for (int i = 0; i < 9; i++) seen[i] = '0;
    #1;
    seen[0] = outw();
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      #1;
      seen[k] = outw();
      if (IRWrite) begin
        seen_n = k;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    int          cycles;
    int          step;
    logic [22:0] word;
  } vec_t;

  vec_t vecs [0:14];

  initial begin
    reset  = 1'b1;
    OpCode = 6'h00;
    Funct  = 6'h00;
    #1;
    check_w("reset_outputs_zero", outw(), 23'd0);
    repeat (2) @(negedge clk);
    #1;
    check_w("reset_held_zero", outw(), W_ZERO);
    reset = 1'b0;
    #1;
    check_w("first_if_after_reset", outw(), W_IF);

    vecs[0]  = '{"lw_mem",      6'h23, 6'h00, 5, 3, cw(L,L,H,H,L,L,L,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0)};
    vecs[1]  = '{"lw_wb",       6'h23, 6'h00, 5, 4, cw(L,L,L,L,L,L,H,L,L,2'd0,2'd1,2'd0,2'd0,2'd0,4'd0)};
    vecs[2]  = '{"sltiu_ex",    6'h0B, 6'h15, 4, 2, cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd1,2'd2,2'd0,4'b1101)};
    vecs[3]  = '{"sltiu_wb",    6'h0B, 6'h00, 4, 3, cw(L,L,L,L,L,L,H,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0)};
    vecs[4]  = '{"addiu_ex",    6'h09, 6'h00, 4, 2, cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd1,2'd2,2'd0,4'b1000)};
    vecs[5]  = '{"beq_ex",      6'h04, 6'h00, 3, 2, cw(L,H,L,L,L,L,L,L,L,2'd0,2'd0,2'd1,2'd0,2'd1,4'b0001)};
    vecs[6]  = '{"jal_id",      6'h03, 6'h00, 2, 1, cw(H,L,L,L,L,L,H,H,L,2'd2,2'd2,2'd0,2'd3,2'd2,4'd0)};
    vecs[7]  = '{"jalr_ex",     6'h00, 6'h09, 3, 2, cw(H,L,L,L,L,L,H,L,L,2'd1,2'd2,2'd0,2'd0,2'd3,4'd0)};
    vecs[8]  = '{"illegal3f_id",6'h3F, 6'h00, 2, 1, cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd0,2'd3,2'd0,4'd0)};
    vecs[9]  = '{"sw_mem",      6'h2B, 6'h00, 4, 3, cw(L,L,H,L,H,L,L,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0)};
    vecs[10] = '{"lui_ex",      6'h0F, 6'h00, 4, 2, cw(L,L,L,L,L,L,L,L,H,2'd0,2'd0,2'd1,2'd2,2'd0,4'd0)};
    vecs[11] = '{"sll_ex",      6'h00, 6'h00, 4, 2, cw(L,L,L,L,L,L,L,L,L,2'd0,2'd0,2'd2,2'd0,2'd0,4'b0010)};
    vecs[12] = '{"badfunct_id", 6'h00, 6'h01, 2, 1, cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd0,2'd3,2'd0,4'd0)};
    vecs[13] = '{"andi_ex",     6'h0C, 6'h00, 4, 2, cw(L,L,L,L,L,L,L,L,L,2'd0,2'd0,2'd1,2'd2,2'd0,4'b0100)};
    vecs[14] = '{"j_if",        6'h02, 6'h00, 2, 0, cw(H,L,L,H,L,H,L,L,L,2'd0,2'd0,2'd0,2'd1,2'd0,4'd0)};

    for (int v = 0; v < 15; v++) begin
      run_instr(vecs[v].op, vecs[v].fn);
      check_i({vecs[v].name, "_cycles"}, seen_n, vecs[v].cycles);
      check_w(vecs[v].name, seen[vecs[v].step], vecs[v].word);
    end

    // Reset during EX of lw: everything drops, then a clean fetch.
    OpCode = 6'h23; Funct = 6'h00;
    @(negedge clk); @(negedge clk); #1;
    check_w("lw_ex_before_abort", outw(), cw(L,L,L,L,L,L,L,H,L,2'd0,2'd0,2'd1,2'd2,2'd0,4'd0));
    reset = 1'b1;
    #1;
    check_w("abort_lw_zero", outw(), W_ZERO);
    @(posedge clk); #1;
    check_w("abort_lw_hold_zero", outw(), W_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_w("abort_lw_release_if", outw(), W_IF);
    @(negedge clk); #1;
    check_w("abort_lw_next_id", outw(), W_ID);
    repeat (4) @(negedge clk);
    #1;
    check_w("abort_lw_refetch_if", outw(), W_IF);

    // Reset during MEM of sw must suppress the store.
    OpCode = 6'h2B;
    repeat (3) @(negedge clk);
    #1;
    check_w("sw_mem_before_abort", outw(), cw(L,L,H,L,H,L,L,L,L,2'd0,2'd0,2'd0,2'd0,2'd0,4'd0));
    reset = 1'b1;
    #1;
    check_w("abort_sw_zero", outw(), W_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_w("abort_sw_release_if", outw(), W_IF);

    // Random instruction stream against the model.
    for (int r = 0; r < 150; r++) begin
      logic [5:0] op, fn;
      logic [5:0] ops [0:11];
      logic [5:0] fns [0:15];
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B};
      fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
              6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h2F};
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
      model(op, fn);
      run_instr(op, fn);
      check_i($sformatf("rand%0d_op%02h_fn%02h_cycles", r, op, fn), seen_n, exp_n);
      for (int k = 0; k < exp_n; k++) begin
        if (seen[k] !== exp_w[k]) begin
          check_w($sformatf("rand%0d_op%02h_fn%02h_step%0d", r, op, fn, k), seen[k], exp_w[k]);
          break;
        end
      end
      tests++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
